jesd204b_tx_link_ctrl: RTL and testbench

Transmit-side JESD204B (subclass 1) link-layer controller for one link. It consumes the synchronized SYNC~ and SYSREF strobes from the link partner and sequences the lane output through Code Group Synchronization (CGS), the Initial Lane Alignment Sequence (ILAS) and user DATA. It also maintains the local multiframe clock (LMFC), phase-aligned to SYSREF. It sits between the transport layer (user samples) and the 8b/10b encoder / serializer, and processes 4 octets per clk.

---
 rtl/jesd204b_tx_link_ctrl.sv | 152 +++++++++++++++
 tb/tb_jesd204b_tx_link_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B subclass-1 transmit link controller: LMFC tracking, CGS/ILAS/DATA
// sequencing and SYNC~ resync filtering for one link, 4 octets per clk.
module jesd204b_tx_link_ctrl #(
  parameter int LMFC_PERIOD = 8,
  parameter int SYNC_FILT   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync_b_i,
  input  logic         sysref_i,
  input  logic [111:0] ilas_cfg_i,
  input  logic [31:0]  tx_data_i,
  output logic         tx_ready_o,
  output logic [31:0]  tx_data_o,
  output logic [3:0]   tx_charisk_o,
  output logic         lmfc_o,
  output logic [1:0]   state_o,
  output logic         sysref_misalign_o
);

  localparam int CW = (LMFC_PERIOD > 1) ? $clog2(LMFC_PERIOD) : 1;

  typedef enum logic [1:0] {CGS = 2'd0, ILAS = 2'd1, DATA = 2'd2} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] lmfc_cnt;
  logic [1:0]    ilas_mf, mf_nx;
  logic          sysref_q, sysref_seen;
  logic [3:0]    filt_cnt;
  logic          sysref_edge, wrap, resync;
  logic [31:0]   ilas_word;
  logic [3:0]    ilas_k;

  assign sysref_edge = sysref_i && !sysref_q;
  assign wrap        = (lmfc_cnt == CW'(LMFC_PERIOD - 1));
  assign resync      = (state != CGS) && !sync_b_i && (filt_cnt == 4'(SYNC_FILT - 1));

  // ILAS word for the current multiframe/word; /A/ is applied last so it
  // wins over config octets when the multiframe is only four words long.
  always_comb begin
    ilas_word = '0;
    ilas_k    = '0;
    if (lmfc_cnt == '0) begin
      ilas_word[7:0] = 8'h1C;
      ilas_k[0]      = 1'b1;
    end
    if (ilas_mf == 2'd1) begin
      if (lmfc_cnt == '0) begin
        ilas_word[15:8]  = 8'h9C;
        ilas_k[1]        = 1'b1;
        ilas_word[31:16] = ilas_cfg_i[15:0];
      end else if (lmfc_cnt == CW'(1)) begin
        ilas_word = ilas_cfg_i[47:16];
      end else if (lmfc_cnt == CW'(2)) begin
        ilas_word = ilas_cfg_i[79:48];
      end else if (lmfc_cnt == CW'(3)) begin
        ilas_word = ilas_cfg_i[111:80];
      end
    end
    if (wrap) begin
      ilas_word[31:24] = 8'h7C;
      ilas_k[3]        = 1'b1;
    end
  end

  // Resync takes precedence over the ILAS->DATA hand-off.
  always_comb begin
    state_nx = state;
    mf_nx    = ilas_mf;
    case (state)
      CGS: begin
        if (wrap && sync_b_i && sysref_seen) begin
          state_nx = ILAS;
          mf_nx    = '0;
        end
      end
      ILAS: begin
        if (resync) begin
          state_nx = CGS;
          mf_nx    = '0;
        end else if (wrap) begin
          if (ilas_mf == 2'd3) begin
            state_nx = DATA;
            mf_nx    = '0;
          end else begin
            mf_nx = ilas_mf + 2'd1;
          end
        end
      end
      DATA: begin
        if (resync) state_nx = CGS;
      end
      default: begin
        state_nx = CGS;
        mf_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= CGS;
      lmfc_cnt          <= '0;
      ilas_mf           <= '0;
      sysref_q          <= 1'b0;
      sysref_seen       <= 1'b0;
      filt_cnt          <= '0;
      tx_data_o         <= 32'hBCBCBCBC;
      tx_charisk_o      <= 4'hF;
      tx_ready_o        <= 1'b0;
      lmfc_o            <= 1'b0;
      state_o           <= 2'd0;
      sysref_misalign_o <= 1'b0;
    end else begin
      state    <= state_nx;
      ilas_mf  <= mf_nx;
      sysref_q <= sysref_i;

      if (sysref_edge) begin
        lmfc_cnt    <= '0;
        sysref_seen <= 1'b1;
      end else begin
        lmfc_cnt <= wrap ? '0 : lmfc_cnt + CW'(1);
      end
      sysref_misalign_o <= sysref_edge && sysref_seen && !wrap;
      lmfc_o            <= sysref_edge || wrap;

      if (state == CGS || sync_b_i || resync) filt_cnt <= '0;
      else                                    filt_cnt <= filt_cnt + 4'd1;

      // Output word reflects this clk's state; ready leads state_o by one clk
      // because it marks the clk in which tx_data_i is captured.
      state_o    <= state;
      tx_ready_o <= (state_nx == DATA);
      case (state)
        ILAS: begin
          tx_data_o    <= ilas_word;
          tx_charisk_o <= ilas_k;
        end
        DATA: begin
          tx_data_o    <= tx_data_i;
          tx_charisk_o <= 4'h0;
        end
        default: begin
          tx_data_o    <= 32'hBCBCBCBC;
          tx_charisk_o <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Randomized bench for jesd204b_tx_link_ctrl with a cycle model built on
// LMFC phase arithmetic and a precomputed ILAS octet stream.
module tb_jesd204b_tx_link_ctrl;
  localparam int P  = 8;
  localparam int SF = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync_b_i;
  logic         sysref_i;
  logic [111:0] ilas_cfg_i;
  logic [31:0]  tx_data_i;
  logic         tx_ready_o;
  logic [31:0]  tx_data_o;
  logic [3:0]   tx_charisk_o;
  logic         lmfc_o;
  logic [1:0]   state_o;
  logic         sysref_misalign_o;

  int total = 0;
  int bad   = 0;

  jesd204b_tx_link_ctrl #(.LMFC_PERIOD(P), .SYNC_FILT(SF)) dut (
    .clk(clk), .reset(reset), .sync_b_i(sync_b_i), .sysref_i(sysref_i),
    .ilas_cfg_i(ilas_cfg_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .tx_data_o(tx_data_o), .tx_charisk_o(tx_charisk_o), .lmfc_o(lmfc_o),
    .state_o(state_o), .sysref_misalign_o(sysref_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ILAS as the octet stream of each multiframe, position = 4*word + octet
  logic [7:0] ils_oct [4][4*P];
  bit         ils_k   [4][4*P];

  task automatic build_ilas();
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 4*P; p++) begin
        ils_oct[m][p] = 8'h00;
        ils_k[m][p]   = 1'b0;
      end
      ils_oct[m][0] = 8'h1C;
      ils_k[m][0]   = 1'b1;
      if (m == 1) begin
        ils_oct[1][1] = 8'h9C;
        ils_k[1][1]   = 1'b1;
        for (int i = 0; i < 14; i++) ils_oct[1][2+i] = ilas_cfg_i[8*i +: 8];
      end
      ils_oct[m][4*P-1] = 8'h7C;
      ils_k[m][4*P-1]   = 1'b1;
    end
  endtask

  // Model: lmfc_cnt(t) = (t - anchor) mod P, anchor = clk in which the count was last forced to 0
  longint     m_cyc = 0, m_anchor = 0;
  bit         m_valid = 0, m_seen, m_sref;
  int         m_mode, m_mf, m_low;
  logic [31:0] e_data;
  logic [3:0]  e_k;
  logic        e_rdy, e_lmfc, e_mis;
  logic [1:0]  e_state;

  always @(posedge clk) begin : model
    int cnt;
    bit edg, wrp, rs;
    if (reset) begin
      e_data = 32'hBCBCBCBC; e_k = 4'hF; e_rdy = 0; e_lmfc = 0; e_state = 0; e_mis = 0;
      m_anchor = m_cyc + 1; m_seen = 0; m_mode = 0; m_mf = 0; m_low = 0; m_sref = 0;
      m_valid = 1;
    end else if (m_valid) begin
      cnt = int'((m_cyc - m_anchor) % P);
      edg = sysref_i && !m_sref;
      wrp = (cnt == P-1);
      if (m_mode == 1) begin
        for (int j = 0; j < 4; j++) begin
          e_data[8*j +: 8] = ils_oct[m_mf][4*cnt+j];
          e_k[j]           = ils_k[m_mf][4*cnt+j];
        end
      end else if (m_mode == 2) begin
        e_data = tx_data_i; e_k = 4'h0;
      end else begin
        e_data = 32'hBCBCBCBC; e_k = 4'hF;
      end
      e_state = 2'(m_mode);
      e_mis   = edg && m_seen && !wrp;
      if (edg) m_anchor = m_cyc + 1;
      e_lmfc  = ((m_cyc + 1 - m_anchor) % P) == 0;
      rs = (m_mode != 0) && !sync_b_i && (m_low + 1 >= SF);
      if (m_mode == 0 || sync_b_i || rs) m_low = 0; else m_low++;
      case (m_mode)
        0: if (wrp && sync_b_i && m_seen) begin m_mode = 1; m_mf = 0; end
        1: if (rs) begin m_mode = 0; m_mf = 0; end
           else if (wrp) begin
             if (m_mf == 3) begin m_mode = 2; m_mf = 0; end else m_mf++;
           end
        default: if (rs) m_mode = 0;
      endcase
      e_rdy  = (m_mode == 2);
      m_seen = m_seen || edg;
      m_sref = sysref_i;
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("data",     tx_data_o, e_data);
      check("charisk",  {28'd0, tx_charisk_o}, {28'd0, e_k});
      check("ready",    {31'd0, tx_ready_o}, {31'd0, e_rdy});
      check("lmfc",     {31'd0, lmfc_o}, {31'd0, e_lmfc});
      check("state",    {30'd0, state_o}, {30'd0, e_state});
      check("misalign", {31'd0, sysref_misalign_o}, {31'd0, e_mis});
    end
  end

  task automatic wait_state(input logic [1:0] want, input int lim);
    int n = 0;
    while (state_o !== want && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", {30'd0, state_o}, {30'd0, want});
  endtask

  initial begin : stim
    logic [127:0] rnd;
    int mc, n, low_left, sr_left;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    ilas_cfg_i = rnd[111:0];
    build_ilas();
    reset = 1; sync_b_i = 0; sysref_i = 0; tx_data_i = 0;

    @(negedge clk);
    check("rst_data",  tx_data_o, 32'hBCBCBCBC);
    check("rst_k",     {28'd0, tx_charisk_o}, 32'hF);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_ready", {31'd0, tx_ready_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;

    // CGS with SYSREF, SYNC~ held low
    repeat (10) @(negedge clk);
    sysref_i = 1;
    repeat (3) @(negedge clk);
    sysref_i = 0;
    repeat (20) @(negedge clk);
    check("cgs_hold", {30'd0, state_o}, 32'd0);

    // ILAS
    sync_b_i = 1;
    wait_state(2'd1, 40);
    check("mf0_w0", tx_data_o, 32'h0000001C);
    check("mf0_w0_k", {28'd0, tx_charisk_o}, 32'h1);
    repeat (P-1) @(negedge clk);
    check("mf0_w7", tx_data_o, 32'h7C000000);
    check("mf0_w7_k", {28'd0, tx_charisk_o}, 32'h8);
    @(negedge clk);
    check("mf1_w0", tx_data_o, {ilas_cfg_i[15:8], ilas_cfg_i[7:0], 8'h9C, 8'h1C});
    check("mf1_w0_k", {28'd0, tx_charisk_o}, 32'h3);
    @(negedge clk);
    check("mf1_w1", tx_data_o, ilas_cfg_i[47:16]);
    wait_state(2'd2, 40);
    check("data_ready", {31'd0, tx_ready_o}, 32'd1);

    // DATA passthrough
    for (int i = 1; i <= 20; i++) begin
      tx_data_i = 32'(i);
      @(negedge clk);
      check("passthru", tx_data_o, 32'(i));
    end

    // short SYNC~ glitch ignored, full-length one resyncs
    sync_b_i = 0;
    repeat (3) @(negedge clk);
    sync_b_i = 1;
    repeat (3) @(negedge clk);
    check("glitch_ign", {30'd0, state_o}, 32'd2);
    sync_b_i = 0;
    repeat (4) @(negedge clk);
    sync_b_i = 1;
    @(negedge clk);
    check("resync_st", {30'd0, state_o}, 32'd0);
    check("resync_bc", tx_data_o, 32'hBCBCBCBC);
    wait_state(2'd1, 40);
    wait_state(2'd2, 60);

    // SYSREF shifted by 3 clks during DATA
    n = 0;
    while (!lmfc_o && n < 20) begin
      tx_data_i = $urandom;
      @(negedge clk);
      n++;
    end
    check("lmfc_found", {31'd0, lmfc_o}, 32'd1);
    repeat (3) @(negedge clk);
    sysref_i = 1;
    mc = 0;
    for (int i = 0; i < 12; i++) begin
      tx_data_i = $urandom;
      if (i == 3) sysref_i = 0;
      @(negedge clk);
      if (sysref_misalign_o) mc++;
    end
    check("misalign_cnt", mc, 32'd1);
    check("realign_data", {30'd0, state_o}, 32'd2);

    // randomized traffic with SYNC~ drops and SYSREF pulses
    low_left = 0; sr_left = 0;
    for (int i = 0; i < 500; i++) begin
      tx_data_i = $urandom;
      if (low_left > 0) begin
        sync_b_i = 0; low_left--;
      end else if ($urandom_range(0, 40) == 0) begin
        sync_b_i = 0; low_left = $urandom_range(0, 5);
      end else begin
        sync_b_i = 1;
      end
      if (sr_left > 0) begin
        sysref_i = 1; sr_left--;
      end else if ($urandom_range(0, 60) == 0) begin
        sysref_i = 1; sr_left = $urandom_range(0, 2);
      end else begin
        sysref_i = 0;
      end
      @(negedge clk);
    end
    sync_b_i = 1; sysref_i = 0;

    // reset in the middle of ILAS MF2
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    sysref_i = 1;
    @(negedge clk);
    sysref_i = 0;
    wait_state(2'd1, 60);
    repeat (2*P + 2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst_data",  tx_data_o, 32'hBCBCBCBC);
    check("midrst_k",     {28'd0, tx_charisk_o}, 32'hF);
    check("midrst_state", {30'd0, state_o}, 32'd0);
    check("midrst_lmfc",  {31'd0, lmfc_o}, 32'd0);

    // SYNC~ high but SYSREF never seen since reset: stay in CGS
    repeat (80) @(negedge clk);
    check("no_sysref_st",   {30'd0, state_o}, 32'd0);
    check("no_sysref_data", tx_data_o, 32'hBCBCBCBC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
